// File: rtl/sram_rd_arbiter.sv
// Round-robin burst arbiter for the shared ext_sram read port. Each grant issues
// req_len+1 incrementing reads; returned words are steered back by an in-order tag pipeline.
module sram_rd_arbiter #(
  parameter int NREQ   = 4,
  parameter int AW     = 26,
  parameter int DW     = 32,
  parameter int LW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*LW-1:0] req_len,
  output logic [NREQ-1:0]   rsp_valid,
  output logic              rsp_last,
  output logic [DW-1:0]     rsp_data,
  output logic              rvalid,
  input  logic              rready,
  output logic [AW-1:0]     raddr,
  input  logic [DW-1:0]     rdata,
  output logic              state_dbg
);

  // Handshakes: a burst request transfers when req_valid[i] & req_ready[i]; a read
  // address transfers when rvalid & rready, and rvalid/raddr hold until it does.
  // Responses carry no ready: rsp_valid beats must be sunk when presented.

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   owner;
  logic [AW-1:0]   cur_addr;
  logic [LW-1:0]   beats;
  logic [PW-1:0]   grant_idx;
  logic            grant_any;
  logic            accept;

  logic [RD_LAT-1:0] tag_v;
  logic [RD_LAT-1:0] tag_l;
  logic [PW-1:0]     tag_o [RD_LAT];

  // Scan from the highest offset down so the nearest requester after rr_ptr wins.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[(int'(rr_ptr) + i) % NREQ]) begin
        grant_any = 1'b1;
        grant_idx = PW'((int'(rr_ptr) + i) % NREQ);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_any && !rst) req_ready[grant_idx] = 1'b1;
  end

  assign accept    = (state == BURST) && rready;
  assign rvalid    = (state == BURST);
  assign raddr     = cur_addr;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      cur_addr <= '0;
      beats    <= '0;
      tag_v    <= '0;
      tag_l    <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_o[i] <= '0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        tag_v[i] <= tag_v[i-1];
        tag_l[i] <= tag_l[i-1];
        tag_o[i] <= tag_o[i-1];
      end
      tag_v[0] <= accept;
      tag_l[0] <= (beats == '0);
      tag_o[0] <= owner;
      case (state)
        IDLE: begin
          if (grant_any) begin
            cur_addr <= req_addr[int'(grant_idx)*AW +: AW];
            beats    <= req_len[int'(grant_idx)*LW +: LW];
            owner    <= grant_idx;
            state    <= BURST;
          end
        end
        BURST: begin
          if (rready) begin
            cur_addr <= cur_addr + 1'b1;
            beats    <= beats - 1'b1;
            if (beats == '0) begin
              rr_ptr <= PW'((int'(owner) + 1) % NREQ);
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // rdata is passed straight through; only the steering/last flags are registered.
  always_comb begin
    rsp_valid = '0;
    rsp_last  = 1'b0;
    if (tag_v[RD_LAT-1]) begin
      rsp_valid[tag_o[RD_LAT-1]] = 1'b1;
      rsp_last                   = tag_l[RD_LAT-1];
    end
  end

  assign rsp_data = rdata;

endmodule

// File: tb/tb_sram_rd_arbiter.sv
// Directed bench for sram_rd_arbiter: an ext_sram read model, a negedge monitor that
// logs grants/accepts/responses, and per-burst expectations checked through a scoreboard.
module tb_sram_rd_arbiter;
  localparam int NREQ = 4, AW = 26, DW = 32, LW = 8, RD_LAT = 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_addr = '0;
  logic [NREQ*LW-1:0]   req_len = '0;
  logic [NREQ-1:0]      rsp_valid;
  logic                 rsp_last;
  logic [DW-1:0]        rsp_data;
  logic                 rvalid;
  logic                 rready = 1'b1;
  logic [AW-1:0]        raddr;
  logic [DW-1:0]        rdata = '0;
  logic                 state_dbg;

  sram_rd_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .LW(LW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len), .rsp_valid(rsp_valid), .rsp_last(rsp_last),
    .rsp_data(rsp_data), .rvalid(rvalid), .rready(rready), .raddr(raddr), .rdata(rdata),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    return {6'h2b, a} ^ 32'h0f0f_0f0f;
  endfunction

  // ext_sram read model, one cycle from address accept to data
  always @(posedge clk) rdata <= (rvalid && rready) ? data_of(raddr) : 32'hdead_beef;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic int oh2idx(input logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  // ---------------- monitor logs ----------------
  logic [AW-1:0] acc_q[$];
  int            acc_cyc_q[$];
  int            gnt_q[$];
  int            gnt_cyc_q[$];
  int            rsp_own_q[$];
  logic          rsp_last_q[$];
  logic [DW-1:0] rsp_data_q[$];
  int            rsp_cyc_q[$];
  logic [DW-1:0] exp_q[$];

  logic [NREQ-1:0] last_grant = '0;
  logic            prev_stall = 1'b0;
  logic [AW-1:0]   prev_addr  = '0;
  logic            hold_valid = 1'b0;
  logic            rnd_rdy    = 1'b0;

  always @(negedge clk) begin
    last_grant = req_ready;
    if (prev_stall) begin
      check_eq("stall_addr_hold", raddr, prev_addr);
      check_eq("stall_rvalid_hold", rvalid, 1);
    end
    prev_stall = rvalid && !rready;
    prev_addr  = raddr;
    if (rvalid && rready) begin
      acc_q.push_back(raddr);
      acc_cyc_q.push_back(cyc);
    end
    if (|req_ready) begin
      check_eq("gnt_onehot", $countones(req_ready), 1);
      gnt_q.push_back(oh2idx(req_ready));
      gnt_cyc_q.push_back(cyc);
    end
    if (|rsp_valid) begin
      check_eq("rsp_onehot", $countones(rsp_valid), 1);
      rsp_own_q.push_back(oh2idx(rsp_valid));
      rsp_last_q.push_back(rsp_last);
      rsp_data_q.push_back(rsp_data);
      rsp_cyc_q.push_back(cyc);
    end
  end

  // ---------------- driver tasks ----------------
  // Granted requesters drop valid on the cycle after their grant; rready optionally random.
  always @(posedge clk) begin
    #1;
    if (!hold_valid) req_valid = req_valid & ~last_grant;
    if (rnd_rdy) rready = 1'($urandom_range(0, 1));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l);
    req_addr[i*AW +: AW] = a;
    req_len[i*LW +: LW]  = l;
    req_valid[i]         = 1'b1;
  endtask

  task automatic clear_logs();
    acc_q.delete(); acc_cyc_q.delete(); gnt_q.delete(); gnt_cyc_q.delete();
    rsp_own_q.delete(); rsp_last_q.delete(); rsp_data_q.delete(); rsp_cyc_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_grants(input string pfx, input int n);
    for (int k = 0; k < 300; k++) begin
      if (gnt_q.size() >= n) return;
      @(negedge clk);
    end
    check_eq({pfx, "_gnt_timeout"}, gnt_q.size(), n);
  endtask

  task automatic wait_accepts(input string pfx, input int n);
    for (int k = 0; k < 300; k++) begin
      if (acc_q.size() >= n) return;
      @(negedge clk);
    end
    check_eq({pfx, "_acc_timeout"}, acc_q.size(), n);
  endtask

  // ---------------- scoreboard ----------------
  task automatic expect_burst(input string pfx, input int owner, input logic [AW-1:0] base,
                              input int n, input bit contig);
    logic [AW-1:0] a;
    int c, c0;
    c0 = 0;
    for (int k = 0; k < n; k++) begin
      if (acc_q.size() == 0 || rsp_own_q.size() == 0) begin
        check_eq({pfx, "_beats_missing"}, k, n);
        return;
      end
      a = base + AW'(k);
      exp_q.push_back(data_of(a));
      c = acc_cyc_q.pop_front();
      if (k == 0) c0 = c;
      check_eq({pfx, "_raddr"}, acc_q.pop_front(), a);
      if (contig) check_eq({pfx, "_b2b"}, c, c0 + k);
      check_eq({pfx, "_rsp_owner"}, rsp_own_q.pop_front(), owner);
      check_eq({pfx, "_rsp_last"}, rsp_last_q.pop_front(), (k == n - 1));
      check_eq({pfx, "_rsp_data"}, rsp_data_q.pop_front(), exp_q.pop_front());
      check_eq({pfx, "_rsp_lat"}, rsp_cyc_q.pop_front(), c + RD_LAT);
    end
  endtask

  task automatic end_test(input string pfx);
    check_eq({pfx, "_acc_left"}, acc_q.size(), 0);
    check_eq({pfx, "_rsp_left"}, rsp_own_q.size(), 0);
    clear_logs();
  endtask

  // ---------------- directed tests ----------------
  int exp_g[8] = '{1, 2, 3, 0, 1, 2, 3, 0};
  int last_acc_cyc;

  initial begin
    // reset state, with a request present to prove the grant is gated during reset
    repeat (2) @(posedge clk);
    #2;
    req_valid = 4'b0001;
    @(negedge clk);
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_rvalid", rvalid, 0);
    check_eq("rst_raddr", raddr, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_last", rsp_last, 0);
    check_eq("rst_state", state_dbg, 0);
    step();
    req_valid = '0;
    step();
    rst = 1'b0;
    run_cycles(2);
    clear_logs();

    // 1: single burst, back-to-back addresses
    set_req(0, 26'h100, 8'd3);
    wait_grants("t1", 1);
    if (gnt_q.size() > 0) check_eq("t1_gnt", gnt_q[0], 0);
    run_cycles(8);
    check_eq("t1_acc_n", acc_q.size(), 4);
    expect_burst("t1", 0, 26'h100, 4, 1'b1);
    end_test("t1");

    // 2: all requesters continuously valid, single-beat bursts
    step();
    hold_valid = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(32'h10 * i), 8'd0);
    wait_grants("t2", 8);
    step();
    req_valid  = '0;
    hold_valid = 1'b0;
    run_cycles(6);
    check_eq("t2_gnt_n", gnt_q.size(), 8);
    for (int k = 0; k < 8 && k < gnt_q.size(); k++) begin
      check_eq("t2_gnt_order", gnt_q[k], exp_g[k]);
      if (k > 0) check_eq("t2_gnt_gap", gnt_cyc_q[k] - gnt_cyc_q[k-1], 2);
    end
    for (int k = 0; k < 8; k++) expect_burst("t2", exp_g[k], AW'(32'h10 * exp_g[k]), 1, 1'b0);
    end_test("t2");

    // 3: rready randomly toggling over an 8-beat burst
    step();
    rnd_rdy = 1'b1;
    set_req(1, 26'h2000, 8'd7);
    wait_grants("t3", 1);
    wait_accepts("t3", 8);
    step();
    rnd_rdy = 1'b0;
    rready  = 1'b1;
    run_cycles(4);
    check_eq("t3_acc_n", acc_q.size(), 8);
    expect_burst("t3", 1, 26'h2000, 8, 1'b0);
    end_test("t3");

    // 4: address wraps at the top of the space
    step();
    set_req(2, 26'h3FF_FFFE, 8'd3);
    wait_grants("t4", 1);
    run_cycles(8);
    if (acc_q.size() == 4) begin
      check_eq("t4_wrap_a2", acc_q[2], 26'h000_0000);
      check_eq("t4_wrap_a3", acc_q[3], 26'h000_0001);
    end
    expect_burst("t4", 2, 26'h3FF_FFFE, 4, 1'b1);
    end_test("t4");

    // 5: request arriving mid-burst waits for the idle cycle after the last accept
    step();
    set_req(1, 26'h3000, 8'd5);
    wait_grants("t5", 1);
    run_cycles(2);
    set_req(2, 26'h3100, 8'd2);
    wait_grants("t5", 2);
    run_cycles(8);
    check_eq("t5_gnt_n", gnt_q.size(), 2);
    check_eq("t5_acc_n", acc_q.size(), 9);
    if (gnt_q.size() == 2 && acc_cyc_q.size() >= 6) begin
      last_acc_cyc = acc_cyc_q[5];
      check_eq("t5_gnt0", gnt_q[0], 1);
      check_eq("t5_gnt1", gnt_q[1], 2);
      check_eq("t5_gnt1_cycle", gnt_cyc_q[1], last_acc_cyc + 1);
    end
    expect_burst("t5a", 1, 26'h3000, 6, 1'b1);
    expect_burst("t5b", 2, 26'h3100, 3, 1'b1);
    end_test("t5");

    // 6: reset mid-burst, then rr_ptr must restart at 0
    step();
    set_req(0, 26'h500, 8'd15);
    wait_grants("t6", 1);
    run_cycles(4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < RD_LAT + 1; k++) begin
      @(negedge clk);
      check_eq("t6_post_rst_rvalid", rvalid, 0);
      check_eq("t6_post_rst_rsp_valid", rsp_valid, 0);
      check_eq("t6_post_rst_state", state_dbg, 0);
    end
    clear_logs();
    step();
    set_req(3, 26'h40, 8'd1);
    set_req(1, 26'h700, 8'd1);
    wait_grants("t6", 2);
    run_cycles(8);
    check_eq("t6_gnt_n", gnt_q.size(), 2);
    if (gnt_q.size() == 2) begin
      check_eq("t6_gnt0", gnt_q[0], 1);
      check_eq("t6_gnt1", gnt_q[1], 3);
    end
    expect_burst("t6a", 1, 26'h700, 2, 1'b1);
    expect_burst("t6b", 3, 26'h40, 2, 1'b1);
    end_test("t6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
